// File: rtl/npu_host_driver.sv
// npu_host_driver
// Host-side initiator for the NPU three-FIFO interface. A start request
// latches three lengths. The block then streams cfg_len words from a
// synchronous ROM into the NPU config FIFO through a 2-entry buffer. After
// that it forwards in_len upstream words into the NPU input FIFO, and drains
// out_len results from the NPU output FIFO to a valid/ready consumer through
// a 2-entry buffer.
//
// Ports
//   CLK, RST                    rising-edge clock, async active-high reset
//   start                       one-cycle run request (ignored unless idle)
//   cfg_len/in_len/out_len      run lengths, sampled on an accepted start
//   cfg_rom_addr, cfg_rom_data  config ROM port (1-cycle read latency)
//   in_data/in_valid/in_ready   upstream input stream
//   res_data/res_valid/res_ready result stream to the consumer
//   npu_config_*                NPU config FIFO write side
//   npu_input_*                 NPU input FIFO write side
//   npu_output_*                NPU output FIFO read side (dout 1 cycle after rd_en)
//   busy, done                  status: busy in CFG/RUN, done pulses once per run
module npu_host_driver #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [CNT_W-1:0]  in_len,
  input  logic [CNT_W-1:0]  out_len,
  output logic [ADDR_W-1:0] cfg_rom_addr,
  input  logic [31:0]       cfg_rom_data,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       npu_config_data,
  output logic              npu_config_fifo_write_enable,
  input  logic              npu_config_fifo_full,
  output logic [31:0]       npu_input_data,
  output logic              npu_input_fifo_write_enable,
  input  logic              npu_input_fifo_full,
  output logic              npu_output_fifo_read_enable,
  input  logic [31:0]       npu_output_data,
  input  logic              npu_output_fifo_empty,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cfg_len_q, cfg_len_d;
  logic [ADDR_W-1:0] fetched_q, fetched_d;
  logic [ADDR_W-1:0] written_q, written_d;
  logic [CNT_W-1:0]  in_len_q, in_len_d;
  logic [CNT_W-1:0]  out_len_q, out_len_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  rd_iss_q, rd_iss_d;
  logic              rom_pend_q, rom_pend_d;
  logic [1:0][31:0]  cbuf_q, cbuf_d;
  logic              cwp_q, cwp_d, crp_q, crp_d;
  logic [1:0]        ccnt_q, ccnt_d;
  logic              rd_fly_q, rd_fly_d;
  logic [1:0][31:0]  rbuf_q, rbuf_d;
  logic              rwp_q, rwp_d, rrp_q, rrp_d;
  logic [1:0]        rcnt_q, rcnt_d;

  logic              in_cfg_s, in_run_s;
  logic              cfg_wr_s, cfg_room_s, cfg_issue_s;
  logic [ADDR_W-1:0] cfg_out_s;
  logic              in_fire_s, rd_en_s;
  logic              res_valid_s, pop_s, pop_buf_s, push_res_s;
  logic [31:0]       res_data_s;

  assign in_cfg_s  = (state_q == S_CFG);
  assign in_run_s  = (state_q == S_RUN);

  // Config path: words outstanding = fetched but not yet written.
  assign cfg_out_s = fetched_q - written_q;
  assign cfg_wr_s  = in_cfg_s && (ccnt_q != 2'd0) && !npu_config_fifo_full;
  // A write happening this cycle already frees its slot, so the 2-deep
  // pipeline keeps one word per cycle in flight instead of stalling.
  assign cfg_room_s  = (cfg_out_s < ADDR_W'(2'd2)) ||
                       (cfg_wr_s && (cfg_out_s == ADDR_W'(2'd2)));
  assign cfg_issue_s = in_cfg_s && (fetched_q < cfg_len_q) && cfg_room_s;

  assign in_fire_s = in_run_s && in_valid && !npu_input_fifo_full &&
                     (in_cnt_q < in_len_q);

  // Result buffer occupancy counts the word landing from the FIFO this cycle.
  assign rd_en_s = in_run_s && !npu_output_fifo_empty &&
                   (({1'b0, rcnt_q} + {2'b00, rd_fly_q}) < 3'd2) &&
                   (rd_iss_q < out_len_q);

  assign res_valid_s = (rcnt_q != 2'd0) || rd_fly_q;
  assign pop_s       = res_valid_s && res_ready;
  assign pop_buf_s   = pop_s && (rcnt_q != 2'd0);
  // A landing word that is consumed straight away never enters the buffer.
  assign push_res_s  = rd_fly_q && !(pop_s && (rcnt_q == 2'd0));

  // Result head: buffered word first, otherwise the word landing from the FIFO.
  always_comb begin
    res_data_s = 32'h0000_0000;
    if (rcnt_q != 2'd0) begin
      res_data_s = rbuf_q[rrp_q];
    end else if (rd_fly_q) begin
      res_data_s = npu_output_data;
    end else begin
      res_data_s = 32'h0000_0000;
    end
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_len == {ADDR_W{1'b0}}) ? S_RUN : S_CFG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        if (written_q == cfg_len_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_CFG;
        end
      end
      S_RUN: begin
        if ((out_cnt_q == out_len_q) && (in_cnt_q == in_len_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next-state logic for lengths, counters and both 2-entry buffers.
  always_comb begin
    cfg_len_d  = cfg_len_q;
    in_len_d   = in_len_q;
    out_len_d  = out_len_q;
    fetched_d  = fetched_q;
    written_d  = written_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    rd_iss_d   = rd_iss_q;
    rom_pend_d = rom_pend_q;
    cbuf_d     = cbuf_q;
    cwp_d      = cwp_q;
    crp_d      = crp_q;
    ccnt_d     = ccnt_q;
    rd_fly_d   = rd_fly_q;
    rbuf_d     = rbuf_q;
    rwp_d      = rwp_q;
    rrp_d      = rrp_q;
    rcnt_d     = rcnt_q;
    if ((state_q == S_IDLE) && start) begin
      cfg_len_d  = cfg_len;
      in_len_d   = in_len;
      out_len_d  = out_len;
      fetched_d  = {ADDR_W{1'b0}};
      written_d  = {ADDR_W{1'b0}};
      in_cnt_d   = {CNT_W{1'b0}};
      out_cnt_d  = {CNT_W{1'b0}};
      rd_iss_d   = {CNT_W{1'b0}};
      rom_pend_d = 1'b0;
      cwp_d      = 1'b0;
      crp_d      = 1'b0;
      ccnt_d     = 2'd0;
      rd_fly_d   = 1'b0;
      rwp_d      = 1'b0;
      rrp_d      = 1'b0;
      rcnt_d     = 2'd0;
    end else begin
      fetched_d  = fetched_q + ADDR_W'(cfg_issue_s);
      written_d  = written_q + ADDR_W'(cfg_wr_s);
      // The ROM answers one edge after the address; capture it one edge later.
      rom_pend_d = cfg_issue_s;
      if (rom_pend_q) begin
        cbuf_d[cwp_q] = cfg_rom_data;
        cwp_d         = ~cwp_q;
      end else begin
        cwp_d = cwp_q;
      end
      if (cfg_wr_s) begin
        crp_d = ~crp_q;
      end else begin
        crp_d = crp_q;
      end
      ccnt_d    = ccnt_q + {1'b0, rom_pend_q} - {1'b0, cfg_wr_s};
      in_cnt_d  = in_cnt_q + CNT_W'(in_fire_s);
      rd_iss_d  = rd_iss_q + CNT_W'(rd_en_s);
      rd_fly_d  = rd_en_s;
      out_cnt_d = out_cnt_q + CNT_W'(pop_s);
      if (push_res_s) begin
        rbuf_d[rwp_q] = npu_output_data;
        rwp_d         = ~rwp_q;
      end else begin
        rwp_d = rwp_q;
      end
      if (pop_buf_s) begin
        rrp_d = ~rrp_q;
      end else begin
        rrp_d = rrp_q;
      end
      rcnt_d = rcnt_q + {1'b0, push_res_s} - {1'b0, pop_buf_s};
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cfg_len_q  <= {ADDR_W{1'b0}};
      in_len_q   <= {CNT_W{1'b0}};
      out_len_q  <= {CNT_W{1'b0}};
      fetched_q  <= {ADDR_W{1'b0}};
      written_q  <= {ADDR_W{1'b0}};
      in_cnt_q   <= {CNT_W{1'b0}};
      out_cnt_q  <= {CNT_W{1'b0}};
      rd_iss_q   <= {CNT_W{1'b0}};
      rom_pend_q <= 1'b0;
      cbuf_q     <= {64{1'b0}};
      cwp_q      <= 1'b0;
      crp_q      <= 1'b0;
      ccnt_q     <= 2'd0;
      rd_fly_q   <= 1'b0;
      rbuf_q     <= {64{1'b0}};
      rwp_q      <= 1'b0;
      rrp_q      <= 1'b0;
      rcnt_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      cfg_len_q  <= cfg_len_d;
      in_len_q   <= in_len_d;
      out_len_q  <= out_len_d;
      fetched_q  <= fetched_d;
      written_q  <= written_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rd_iss_q   <= rd_iss_d;
      rom_pend_q <= rom_pend_d;
      cbuf_q     <= cbuf_d;
      cwp_q      <= cwp_d;
      crp_q      <= crp_d;
      ccnt_q     <= ccnt_d;
      rd_fly_q   <= rd_fly_d;
      rbuf_q     <= rbuf_d;
      rwp_q      <= rwp_d;
      rrp_q      <= rrp_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign cfg_rom_addr                 = fetched_q;
  assign npu_config_data              = cbuf_q[crp_q];
  assign npu_config_fifo_write_enable = cfg_wr_s;
  assign in_ready                     = in_fire_s;
  assign npu_input_fifo_write_enable  = in_fire_s;
  assign npu_input_data               = in_data;
  assign npu_output_fifo_read_enable  = rd_en_s;
  assign res_valid                    = res_valid_s;
  assign res_data                     = res_data_s;
  assign busy                         = in_cfg_s || in_run_s;
  assign done                         = (state_q == S_DONE);

endmodule
